// File: rtl/pipe_dest_tracker.sv
// pipe_dest_tracker
//   Carries each instruction's destination register, register-file write
//   enable and load flag from ID through the EX, MEM and WB slots. The slot
//   contents are the hazard-status signals for the data hazard unit. That
//   unit's NOP request inserts a bubble into EX. Load-use stall cycles are
//   counted for performance debug.
//
// Ports
//   clk        in   pipeline clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   ID_RD      in   destination register of the instruction in ID
//   ID_RF_LE   in   instruction in ID writes the register file
//   ID_L       in   instruction in ID is a load
//   NOP        in   bubble request from the hazard unit (load-use stall)
//   FLUSH      in   squash the instruction in ID
//   HOLD       in   global pipeline freeze
//   CNT_CLR    in   synchronous clear of STALL_CNT
//   EX_/MEM_/WB_RD, EX_/MEM_/WB_RF_LE, EX_L   out   slot contents
//   PIPE_EMPTY out   no write enable set in EX, MEM or WB
//   STALL_CNT  out   saturating count of stall cycles
module pipe_dest_tracker #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       ID_RD,
  input  logic             ID_RF_LE,
  input  logic             ID_L,
  input  logic             NOP,
  input  logic             FLUSH,
  input  logic             HOLD,
  input  logic             CNT_CLR,
  output logic [4:0]       EX_RD,
  output logic [4:0]       MEM_RD,
  output logic [4:0]       WB_RD,
  output logic             EX_RF_LE,
  output logic             MEM_RF_LE,
  output logic             WB_RF_LE,
  output logic             EX_L,
  output logic             PIPE_EMPTY,
  output logic [CNT_W-1:0] STALL_CNT
);

  logic [4:0]       ex_rd_reg, mem_rd_reg, wb_rd_reg;
  logic             ex_rf_le_reg, mem_rf_le_reg, wb_rf_le_reg;
  logic             ex_l_reg, mem_l_reg, wb_l_reg;
  logic [CNT_W-1:0] stall_cnt_reg;

  // GR0 is hardwired zero: an instruction targeting it must never be seen
  // as a producer, so its write enable and load flag are dropped at entry.
  logic id_not_gr0;
  logic bubble;
  logic cnt_full;

  assign id_not_gr0 = (ID_RD != 5'd0);
  assign bubble     = NOP | FLUSH;
  assign cnt_full   = &stall_cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_rd_reg     <= '0;
      ex_rf_le_reg  <= 1'b0;
      ex_l_reg      <= 1'b0;
      mem_rd_reg    <= '0;
      mem_rf_le_reg <= 1'b0;
      mem_l_reg     <= 1'b0;
      wb_rd_reg     <= '0;
      wb_rf_le_reg  <= 1'b0;
      wb_l_reg      <= 1'b0;
    end else if (!HOLD) begin
      if (bubble) begin
        ex_rd_reg    <= '0;
        ex_rf_le_reg <= 1'b0;
        ex_l_reg     <= 1'b0;
      end else begin
        ex_rd_reg    <= ID_RD;
        ex_rf_le_reg <= ID_RF_LE & id_not_gr0;
        ex_l_reg     <= ID_L & id_not_gr0;
      end
      // Older instructions keep draining even while EX takes a bubble.
      mem_rd_reg    <= ex_rd_reg;
      mem_rf_le_reg <= ex_rf_le_reg;
      mem_l_reg     <= ex_l_reg;
      wb_rd_reg     <= mem_rd_reg;
      wb_rf_le_reg  <= mem_rf_le_reg;
      wb_l_reg      <= mem_l_reg;
    end
  end

  // Clear is honoured even under HOLD and beats a simultaneous increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_reg <= '0;
    end else if (CNT_CLR) begin
      stall_cnt_reg <= '0;
    end else if (NOP && !HOLD && !cnt_full) begin
      stall_cnt_reg <= stall_cnt_reg + 1'b1;
    end
  end

  assign EX_RD      = ex_rd_reg;
  assign MEM_RD     = mem_rd_reg;
  assign WB_RD      = wb_rd_reg;
  assign EX_RF_LE   = ex_rf_le_reg;
  assign MEM_RF_LE  = mem_rf_le_reg;
  assign WB_RF_LE   = wb_rf_le_reg;
  assign EX_L       = ex_l_reg;
  assign PIPE_EMPTY = ~(ex_rf_le_reg | mem_rf_le_reg | wb_rf_le_reg);
  assign STALL_CNT  = stall_cnt_reg;

  // The WB load flag travels with the slot for completeness but is not
  // exported; fold it into an unused sink so its intent stays visible.
  logic unused_wb_l;
  assign unused_wb_l = wb_l_reg ^ mem_l_reg;

endmodule

// File: doc/pipe_dest_tracker.md
# pipe_dest_tracker

Destination-register tracker for the 32-bit PA-RISC pipeline: carries each instruction's destination register, register-file write enable and load flag from ID through EX, MEM and WB. It is the producer of the EX/MEM/WB hazard-status signals consumed by the data hazard detection unit, and consumes that unit's NOP request to insert bubbles. It also counts load-use stall cycles for performance debug.

## Interface
Parameters:
- CNT_W, 16, width of the stall-cycle counter

Ports:
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- ID_RD  in  5  destination register of the instruction in ID
- ID_RF_LE  in  1  instruction in ID writes the register file
- ID_L  in  1  instruction in ID is a load
- NOP  in  1  bubble request from hazard unit (load-use stall)
- FLUSH  in  1  squash instruction in ID (taken branch / nullify)
- HOLD  in  1  global pipeline freeze (memory wait)
- CNT_CLR  in  1  synchronous clear of STALL_CNT
- EX_RD, MEM_RD, WB_RD  out  5 each  destination register per stage
- EX_RF_LE, MEM_RF_LE, WB_RF_LE  out  1 each  write enable per stage
- EX_L  out  1  instruction in EX is a load
- PIPE_EMPTY  out  1  no write enable set in EX, MEM or WB
- STALL_CNT  out  CNT_W  saturating count of stall cycles

## Operation
- Each stage (EX, MEM, WB) is a register slot {RD, RF_LE, L}; the bubble value is {0, 0, 0}.
- GR0 masking at entry: if ID_RD == 0, the captured EX slot has RF_LE = 0 and L = 0 (GR0 is hardwired zero; it never forwards or stalls). RD is still captured as 0.
- Per-cycle update when HOLD = 0:
  - EX <= bubble if NOP or FLUSH, else masked {ID_RD, ID_RF_LE, ID_L}
  - MEM <= EX
  - WB <= MEM
- NOP and FLUSH together: a bubble enters EX. The pair is legal, and the result is the same as either signal alone.
- A bubble affects only EX. MEM and WB keep advancing during a stall, so the older instruction drains.
- HOLD = 1 has highest priority. All three slots keep their values, and NOP, FLUSH and counter increments are ignored that cycle. CNT_CLR is still honoured.
- STALL_CNT behaviour:
  - Increments by 1 on each edge with NOP = 1 and HOLD = 0.
  - Saturates at all-ones and never wraps.
  - CNT_CLR = 1 forces 0 on the next edge and wins over a simultaneous increment.
- PIPE_EMPTY = ~(EX_RF_LE | MEM_RF_LE | WB_RF_LE). It is combinational from the slot registers.
- All other outputs come directly from registers. There is no combinational path from inputs to outputs.

## Timing
- Reset (rst_n low, asynchronous): all slot fields = 0, STALL_CNT = 0, so PIPE_EMPTY = 1. Release is synchronous to the first clk edge with rst_n high.
- Reset asserted mid-operation clears all slots immediately, without waiting for clk.
- Latency: ID values appear on EX_* 1 edge later, on MEM_* after 2 edges and on WB_* after 3 edges, with HOLD = 0 throughout.
- Each HOLD cycle adds exactly 1 cycle of latency to every in-flight slot.
- NOP is sampled on the same edge that would have captured the stalled instruction. The hazard unit keeps the ID instruction in place (via its LE), and that instruction is captured on the first edge where NOP = 0.
- One NOP cycle after a load in EX produces the sequence EX = bubble, MEM = load. The hazard unit then sees the load in MEM and forwards from that stage.

## Test plan
- Straight flow: drive ID_RD = 5, 6, 7 with RF_LE = 1 on 3 consecutive edges. Required: after edge 3, EX_RD = 7, MEM_RD = 6, WB_RD = 5, with all RF_LE = 1.
- Load-use stall:
  - Stimulus: load with ID_RD = 9, ID_L = 1, then NOP = 1 for 1 cycle.
  - Required: EX_RF_LE = 0, EX_L = 0 and MEM_RD = 9 with MEM_RF_LE = 1. STALL_CNT = 1.
- GR0 masking: ID_RD = 0, ID_RF_LE = 1, ID_L = 1. Required: EX_RD = 0, EX_RF_LE = 0, EX_L = 0, and PIPE_EMPTY stays 1 if the pipe was empty.
- HOLD:
  - Stimulus: fill with RD 1, 2, 3, then HOLD = 1 with NOP = 1 for 2 cycles.
  - Required: slots unchanged and STALL_CNT unchanged. After HOLD drops, shifting resumes.
- Counter saturation/clear:
  - Stimulus: CNT_W = 4, NOP held for 20 cycles.
  - Required: STALL_CNT = 15. With CNT_CLR = 1 and NOP = 1 on the same edge, STALL_CNT = 0.
- Async reset mid-flow: assert rst_n = 0 between clock edges with all slots valid. Required: all outputs 0 and PIPE_EMPTY = 1 immediately, before the next edge.
